// File: rtl/quad_decode_counter.sv
// Quadrature decoder with up/down position counter.
// Encoder phases A/B are synchronised with two flops each, then glitch-filtered.
// Position changes are decoded from successive filtered {A,B} values.
// Up sequence {A,B}: 00 -> 10 -> 11 -> 01 -> 00. The reverse order counts down.
// A change of both bits at once cannot be decoded, so it only sets the sticky err flag.
module quad_decode_counter #(
  parameter int WIDTH    = 8,
  parameter int FILT_CYC = 4
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             cnt_clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  // A 4-bit counter covers FILT_CYC values up to 15.
  localparam int CW = 4;
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT_CYC - 1);

  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    s2_prev;
  logic [1:0]    filt;
  logic [1:0]    prev;
  logic [CW-1:0] stab_cnt;
  logic          primed;

  logic          stable;
  logic          differs;
  logic          filt_hit;
  logic          prime_load;
  logic [1:0]    idx_filt;
  logic [1:0]    idx_prev;
  logic [1:0]    delta;
  logic          moved;
  logic          go_up;
  logic          go_down;
  logic          illegal;

  // Two-flop synchroniser per phase, plus the previous synchroniser output for stability checks.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      sync1   <= 2'b00;
      sync2   <= 2'b00;
      s2_prev <= 2'b00;
    end else begin
      sync1   <= {a_in, b_in};
      sync2   <= sync1;
      s2_prev <= sync2;
    end
  end

  // Decide whether the synchronised value has stayed put long enough to be accepted.
  always_comb begin
    stable     = (sync2 == s2_prev);
    differs    = (sync2 != filt);
    filt_hit   = stable && (differs || !primed) && (stab_cnt == FILT_LAST);
    prime_load = filt_hit && !primed;
  end

  // Glitch filter. Before priming, it only waits for any stable value.
  // After priming, it waits for a stable value that differs from filt.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      filt     <= 2'b00;
      stab_cnt <= '0;
      primed   <= 1'b0;
    end else if (stable && (differs || !primed)) begin
      if (stab_cnt == FILT_LAST) begin
        filt     <= sync2;
        stab_cnt <= '0;
        primed   <= 1'b1;
      end else begin
        stab_cnt <= stab_cnt + CW'(1);
      end
    end else begin
      stab_cnt <= '0;
    end
  end

  // Map each Gray phase to its position on the up circle (00=0, 10=1, 11=2, 01=3).
  // The modulo-4 distance from prev to filt then gives the kind of move.
  always_comb begin
    idx_filt = {filt[0], filt[1] ^ filt[0]};
    idx_prev = {prev[0], prev[1] ^ prev[0]};
    delta    = idx_filt - idx_prev;
    moved    = primed && (prev != filt);
    go_up    = moved && (delta == 2'd1);
    go_down  = moved && (delta == 2'd3);
    illegal  = moved && (delta == 2'd2);
  end

  // Registered decode: update position, direction, step pulse and sticky error.
  // cnt_clr beats a step for the count value, but step and dir still report the move.
  // An illegal move beats err_clr.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      prev  <= 2'b00;
      count <= '0;
      dir   <= 1'b1;
      step  <= 1'b0;
      err   <= 1'b0;
    end else begin
      step <= go_up || go_down;

      if (prime_load) begin
        prev <= sync2;
      end else if (moved) begin
        prev <= filt;
      end

      if (cnt_clr) begin
        count <= '0;
      end else if (go_up) begin
        count <= count + WIDTH'(1);
      end else if (go_down) begin
        count <= count - WIDTH'(1);
      end

      if (go_up) begin
        dir <= 1'b1;
      end else if (go_down) begin
        dir <= 1'b0;
      end

      if (illegal) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_decode_counter.sv
// Testbench for quad_decode_counter.
// Stimulus tasks move the encoder and push each expected step result ({dir,count}) into exp_q.
// A monitor pops exp_q and compares it with the outputs whenever step is high.
// The reference model walks the up-sequence table directly.
module tb_quad_decode_counter;

  localparam int WIDTH    = 8;
  localparam int FILT_CYC = 4;

  // clock / reset block
  logic             clock = 1'b0;
  logic             clr_n;
  logic             a_in;
  logic             b_in;
  logic             cnt_clr;
  logic             err_clr;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             step;
  logic             err;

  always #5 clock = ~clock;

  quad_decode_counter #(.WIDTH(WIDTH), .FILT_CYC(FILT_CYC)) dut (
    .clock   (clock),
    .clr_n   (clr_n),
    .a_in    (a_in),
    .b_in    (b_in),
    .cnt_clr (cnt_clr),
    .err_clr (err_clr),
    .count   (count),
    .dir     (dir),
    .step    (step),
    .err     (err)
  );

  // scoreboard state and reference model
  logic [WIDTH:0]   exp_q[$];
  int               checks = 0;
  int               passes = 0;
  int               steps_seen = 0;
  logic [1:0]       m_ab;
  logic [WIDTH-1:0] m_pos;
  logic             m_dir;
  logic             m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [1:0] up_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] down_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // driver tasks
  task automatic drive_ab(input logic [1:0] ab);
    a_in = ab[1];
    b_in = ab[0];
  endtask

  task automatic move(input logic [1:0] nxt, input int hold);
    if (nxt == up_next(m_ab)) begin
      m_pos = m_pos + 1'b1;
      m_dir = 1'b1;
      exp_q.push_back({1'b1, m_pos});
    end else if (m_ab == up_next(nxt)) begin
      m_pos = m_pos - 1'b1;
      m_dir = 1'b0;
      exp_q.push_back({1'b0, m_pos});
    end else if (nxt != m_ab) begin
      m_err = 1'b1;
    end
    m_ab = nxt;
    drive_ab(nxt);
    repeat (hold) @(negedge clock);
  endtask

  task automatic pulse_cnt_clr();
    cnt_clr = 1'b1;
    @(negedge clock);
    cnt_clr = 1'b0;
    m_pos = '0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    m_err = 1'b0;
  endtask

  // monitor: every step pulse must match the oldest expected move
  always @(negedge clock) begin
    logic [WIDTH:0] e;
    if (clr_n === 1'b1 && step === 1'b1) begin
      steps_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_step: step=1 with nothing expected, count=%0d (t=%0t)", count, $time);
      end else begin
        e = exp_q.pop_front();
        check("step_count", 32'(count), 32'(e[WIDTH-1:0]));
        check("step_dir", 32'(dir), 32'(e[WIDTH]));
      end
    end
  end

  // watchdog
  initial begin
    #2000000;
    checks++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int r;
    logic [1:0] nxt;
    logic [1:0] gbit;

    clr_n = 1'b0; a_in = 1'b0; b_in = 1'b0; cnt_clr = 1'b0; err_clr = 1'b0;
    m_ab = 2'b00; m_pos = '0; m_dir = 1'b1; m_err = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_count", 32'(count), 0);
    check("reset_dir", 32'(dir), 1);
    check("reset_step", 32'(step), 0);
    check("reset_err", 32'(err), 0);
    clr_n = 1'b1;
    repeat (10) @(negedge clock);

    // 8 full up cycles
    s0 = steps_seen;
    for (int i = 0; i < 32; i++) move(up_next(m_ab), 10);
    repeat (12) @(negedge clock);
    check("up32_count", 32'(count), 32);
    check("up32_dir", 32'(dir), 1);
    check("up32_err", 32'(err), 0);
    check("up32_steps", steps_seen - s0, 32);

    // wrap downward from zero, then all the way round
    pulse_cnt_clr();
    check("clr_count", 32'(count), 0);
    move(down_next(m_ab), 10);
    check("down_wrap_count", 32'(count), 255);
    check("down_wrap_dir", 32'(dir), 0);
    for (int i = 0; i < 255; i++) move(down_next(m_ab), 8);
    repeat (10) @(negedge clock);
    check("down256_count", 32'(count), 0);

    // wrap upward through 255 -> 0
    move(down_next(m_ab), 8);
    move(down_next(m_ab), 8);
    repeat (10) @(negedge clock);
    check("at254_count", 32'(count), 254);
    move(up_next(m_ab), 10);
    check("up255_count", 32'(count), 255);
    move(up_next(m_ab), 10);
    check("up_wrap_count", 32'(count), 0);
    check("up_wrap_dir", 32'(dir), 1);

    // 3-cycle glitch on a_in must vanish
    s0 = steps_seen;
    a_in = ~a_in;
    repeat (3) @(negedge clock);
    a_in = ~a_in;
    repeat (12) @(negedge clock);
    check("glitch_count", 32'(count), 0);
    check("glitch_err", 32'(err), 0);
    check("glitch_steps", steps_seen - s0, 0);

    // latency: input changes now, first sampled at posedge 1.
    // Sample edge N is posedge 2, when the synchroniser output takes the new value.
    // step and the new count must first appear after posedge N+6 = 8.
    move(up_next(m_ab), 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 7) begin
        check("lat_step_early", 32'(step), 0);
        check("lat_count_early", 32'(count), 32'(m_pos - 1'b1));
      end
      if (k == 8) begin
        check("lat_step", 32'(step), 1);
        check("lat_count", 32'(count), 32'(m_pos));
      end
    end
    repeat (4) @(negedge clock);

    // illegal transition, err_clr, then err_clr racing a new illegal move
    s0 = steps_seen;
    move(~m_ab, 10);
    repeat (2) @(negedge clock);
    check("illegal_err", 32'(err), 1);
    check("illegal_count", 32'(count), 32'(m_pos));
    check("illegal_steps", steps_seen - s0, 0);
    pulse_err_clr();
    check("err_clr", 32'(err), 0);
    move(~m_ab, 0);
    repeat (7) @(negedge clock);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    check("err_clr_race", 32'(err), 1);
    repeat (4) @(negedge clock);
    check("err_clr_race_hold", 32'(err), 1);

    // cnt_clr coinciding with an up step at count=17
    pulse_cnt_clr();
    for (int i = 0; i < 17; i++) move(up_next(m_ab), 8);
    repeat (10) @(negedge clock);
    check("at17_count", 32'(count), 17);
    nxt = up_next(m_ab);
    m_ab = nxt;
    m_pos = '0;
    m_dir = 1'b1;
    exp_q.push_back({1'b1, m_pos});
    drive_ab(nxt);
    repeat (7) @(negedge clock);
    cnt_clr = 1'b1;
    @(negedge clock);
    cnt_clr = 1'b0;
    check("cntclr_step", 32'(step), 1);
    check("cntclr_count", 32'(count), 0);
    check("cntclr_dir", 32'(dir), 1);
    repeat (4) @(negedge clock);

    // asynchronous reset in the middle of a filtered change
    move(down_next(m_ab), 10);
    move(~m_ab, 10);
    repeat (2) @(negedge clock);
    check("pre_rst_dir", 32'(dir), 0);
    check("pre_rst_err", 32'(err), 1);
    drive_ab(up_next(m_ab));
    repeat (4) @(negedge clock);
    #2 clr_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 0);
    check("async_rst_dir", 32'(dir), 1);
    check("async_rst_step", 32'(step), 0);
    check("async_rst_err", 32'(err), 0);
    @(negedge clock);
    drive_ab(2'b11);
    exp_q.delete();
    m_ab = 2'b11; m_pos = '0; m_dir = 1'b1; m_err = 1'b0;
    @(negedge clock);
    clr_n = 1'b1;
    s0 = steps_seen;
    repeat (20) @(negedge clock);
    check("prime_count", 32'(count), 0);
    check("prime_err", 32'(err), 0);
    check("prime_steps", steps_seen - s0, 0);
    move(up_next(m_ab), 10);
    check("post_prime_count", 32'(count), 1);
    check("post_prime_dir", 32'(dir), 1);

    // randomized mix of legal moves, illegal moves, glitches and clears
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        move(up_next(m_ab), $urandom_range(6, 14));
      end else if (r <= 5) begin
        move(down_next(m_ab), $urandom_range(6, 14));
      end else if (r == 6) begin
        move(~m_ab, 10);
        check("rand_illegal_err", 32'(err), 32'(m_err));
      end else if (r == 7) begin
        gbit = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
        drive_ab(m_ab ^ gbit);
        repeat ($urandom_range(1, FILT_CYC - 1)) @(negedge clock);
        drive_ab(m_ab);
        repeat (6) @(negedge clock);
      end else if (r == 8) begin
        repeat (10) @(negedge clock);
        pulse_err_clr();
        check("rand_err_clr", 32'(err), 0);
      end else begin
        repeat (10) @(negedge clock);
        pulse_cnt_clr();
        check("rand_cnt_clr", 32'(count), 0);
      end
    end
    repeat (15) @(negedge clock);
    check("final_pending_steps", exp_q.size(), 0);
    check("final_count", 32'(count), 32'(m_pos));
    check("final_dir", 32'(dir), 32'(m_dir));
    check("final_err", 32'(err), 32'(m_err));

    // final report
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
